// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift-register sequencer: register mode selects,
// command op codes and FSM states.
package shift_seq_pkg;

    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic [1:0] OP_CLR   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SHR   = 2'b10;
    localparam logic [1:0] OP_SHL   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/shift_seq_downcnt.sv
// Loadable down-counter tracking remaining shift cycles; flags zero and
// the final count so the sequencer can exit on the last shift cycle.
module shift_seq_downcnt
    import shift_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             last
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    assign last = (cnt_q == ONE);

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a universal shift register (clear/load/shift).
// Define SHIFT_SEQ_ROTATE_EN to take the fill bit from reg_q (rotate mode).
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    input  logic             abort,
    input  logic [WIDTH-1:0] reg_q,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] par_out,
    output logic             rightshift,
    output logic             leftshift,
    output logic             reg_sync_reset,
    output logic [CNT_W-1:0] busy_cnt,
    output logic             done,
    output logic             aborted
);

    state_e           state_d, state_q;
    logic [1:0]       sel_d, sel_q;
    logic [WIDTH-1:0] par_d, par_q;
    logic             rs_d, rs_q;
    logic             ls_d, ls_q;
    logic             srst_d, srst_q;
    logic             done_d, done_q;
    logic             aborted_d, aborted_q;

    logic             cnt_load, cnt_dec, cnt_clr, cnt_zero, cnt_last;
    logic             fill_r_new, fill_l_new, fill_r_hold, fill_l_hold;

`ifdef SHIFT_SEQ_ROTATE_EN
    // Rotate: the bit leaving one end is fed back into the other end.
    assign fill_r_new  = reg_q[0];
    assign fill_l_new  = reg_q[WIDTH-1];
    assign fill_r_hold = reg_q[0];
    assign fill_l_hold = reg_q[WIDTH-1];
    logic unused_cmd_fill;
    assign unused_cmd_fill = cmd_fill;
`else
    assign fill_r_new  = cmd_fill;
    assign fill_l_new  = cmd_fill;
    assign fill_r_hold = rs_q;
    assign fill_l_hold = ls_q;
    logic unused_reg_q;
    assign unused_reg_q = ^reg_q;
`endif

    shift_seq_downcnt #(.CNT_W(CNT_W)) u_downcnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cmd_count),
        .dec      (cnt_dec),
        .clr      (cnt_clr),
        .cnt      (busy_cnt),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = SEL_HOLD;
        par_d     = '0;
        rs_d      = 1'b0;
        ls_d      = 1'b0;
        srst_d    = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_CLR: begin
                            state_d = ST_CLR;
                            srst_d  = 1'b1;
                        end
                        OP_LOAD: begin
                            state_d = ST_LOAD;
                            sel_d   = SEL_LOAD;
                            par_d   = cmd_data;
                        end
                        default: begin
                            // A zero-length shift completes without any active cycle.
                            if (cmd_count == '0) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d  = ST_SHIFT;
                                cnt_load = 1'b1;
                                if (cmd_op == OP_SHR) begin
                                    sel_d = SEL_SHR;
                                    rs_d  = fill_r_new;
                                end else begin
                                    sel_d = SEL_SHL;
                                    ls_d  = fill_l_new;
                                end
                            end
                        end
                    endcase
                end
            end
            ST_CLR, ST_LOAD: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    cnt_clr   = 1'b1;
                end else if (cnt_last || cnt_zero) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    cnt_dec = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    sel_d   = sel_q;
                    if (sel_q == SEL_SHR) begin
                        rs_d = fill_r_hold;
                    end else begin
                        ls_d = fill_l_hold;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_HOLD;
            par_q     <= '0;
            rs_q      <= 1'b0;
            ls_q      <= 1'b0;
            srst_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            par_q     <= par_d;
            rs_q      <= rs_d;
            ls_q      <= ls_d;
            srst_q    <= srst_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign cmd_ready      = (state_q == ST_IDLE);
    assign sel            = sel_q;
    assign par_out        = par_q;
    assign rightshift     = rs_q;
    assign leftshift      = ls_q;
    assign reg_sync_reset = srst_q;
    assign done           = done_q;
    assign aborted        = aborted_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer; expected values are hand-computed per step.
module tb_shift_sequencer;

`ifdef SHIFT_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_data;
    logic [3:0] cmd_count;
    logic       cmd_fill;
    logic       abort;
    logic [1:0] reg_q;
    logic [1:0] sel;
    logic [1:0] par_out;
    logic       rightshift;
    logic       leftshift;
    logic       reg_sync_reset;
    logic [3:0] busy_cnt;
    logic       done;
    logic       aborted;

    int total;
    int passed;

    shift_sequencer #(.WIDTH(2), .CNT_W(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .cmd_count      (cmd_count),
        .cmd_fill       (cmd_fill),
        .abort          (abort),
        .reg_q          (reg_q),
        .sel            (sel),
        .par_out        (par_out),
        .rightshift     (rightshift),
        .leftshift      (leftshift),
        .reg_sync_reset (reg_sync_reset),
        .busy_cnt       (busy_cnt),
        .done           (done),
        .aborted        (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packs every registered output into one word for compact checks.
    function automatic logic [31:0] outs();
        return {18'd0, sel, par_out, rightshift, leftshift, reg_sync_reset, busy_cnt, done, aborted};
    endfunction

    function automatic logic [31:0] pack(input logic [1:0] s, input logic [1:0] p, input logic r,
                                         input logic l, input logic c, input logic [3:0] b,
                                         input logic d, input logic a);
        return {18'd0, s, p, r, l, c, b, d, a};
    endfunction

    task automatic issue(input logic [1:0] op, input logic [1:0] data, input logic [3:0] cnt,
                         input logic fill);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_count = cnt;
        cmd_fill  = fill;
        tick();
        cmd_valid = 1'b0;
        cmd_data  = ~data;
        cmd_count = 4'd9;
        cmd_fill  = ~fill;
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 2'b00;
        cmd_count = 4'd0;
        cmd_fill  = 1'b0;
        abort     = 1'b0;
        reg_q     = 2'b01;

        tick();
        tick();
        chk("reset_outs", outs(), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("ready_after_reset", cmd_ready, 1'b1);

        // LOAD 2'b10
        issue(2'b01, 2'b10, 4'd0, 1'b0);
        chk("load_k1", outs(), pack(2'b11, 2'b10, 0, 0, 0, 4'd0, 0, 0));
        chk("load_k1_ready", cmd_ready, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("load_k2_done", outs(), pack(2'b00, 2'b00, 0, 0, 0, 4'd0, 1, 0));
        chk("load_k2_ready", cmd_ready, 1'b0);
        tick();
        chk("load_k3_ready", cmd_ready, 1'b1);
        chk("load_k3_outs", outs(), 32'd0);

        // SHR count 3, fill 1
        issue(2'b10, 2'b00, 4'd3, 1'b1);
        chk("shr_c1", outs(), pack(2'b01, 2'b00, 1, 0, 0, 4'd3, 0, 0));
        tick();
        chk("shr_c2", outs(), pack(2'b01, 2'b00, 1, 0, 0, 4'd2, 0, 0));
        tick();
        chk("shr_c3", outs(), pack(2'b01, 2'b00, 1, 0, 0, 4'd1, 0, 0));
        tick();
        chk("shr_done", outs(), pack(2'b00, 2'b00, 0, 0, 0, 4'd0, 1, 0));
        tick();
        chk("shr_ready", cmd_ready, 1'b1);

        // SHL count 5, fill 1, abort in 2nd shift cycle
        issue(2'b11, 2'b00, 4'd5, 1'b1);
        chk("shl_c1", outs(), pack(2'b10, 2'b00, 0, ROT ? 1'b0 : 1'b1, 0, 4'd5, 0, 0));
        tick();
        chk("shl_c2", outs(), pack(2'b10, 2'b00, 0, ROT ? 1'b0 : 1'b1, 0, 4'd4, 0, 0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("shl_abort_done", outs(), pack(2'b00, 2'b00, 0, 0, 0, 4'd0, 1, 1));
        tick();
        chk("shl_abort_idle", outs(), 32'd0);
        chk("shl_abort_ready", cmd_ready, 1'b1);

        // SHR count 1 with abort in its only (last) shift cycle
        issue(2'b10, 2'b00, 4'd1, 1'b1);
        chk("last_c1", outs(), pack(2'b01, 2'b00, 1, 0, 0, 4'd1, 0, 0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("last_abort_done", outs(), pack(2'b00, 2'b00, 0, 0, 0, 4'd0, 1, 1));
        tick();

        // SHR count 0: done straight away
        issue(2'b10, 2'b00, 4'd0, 1'b1);
        chk("zero_done", outs(), pack(2'b00, 2'b00, 0, 0, 0, 4'd0, 1, 0));
        chk("zero_ready", cmd_ready, 1'b0);
        tick();
        chk("zero_ready_back", cmd_ready, 1'b1);

        // CLR, with abort ignored while clearing
        issue(2'b00, 2'b00, 4'd0, 1'b0);
        chk("clr_k1", outs(), pack(2'b00, 2'b00, 0, 0, 1, 4'd0, 0, 0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("clr_k2_done", outs(), pack(2'b00, 2'b00, 0, 0, 0, 4'd0, 1, 0));
        tick();
        chk("clr_k3_ready", cmd_ready, 1'b1);

        // Reset dropped in 2nd cycle of a count-4 shift
        issue(2'b10, 2'b00, 4'd4, 1'b1);
        chk("rst_c1", busy_cnt, 4'd4);
        tick();
        chk("rst_c2", outs(), pack(2'b01, 2'b00, 1, 0, 0, 4'd3, 0, 0));
        reset_n = 1'b0;
        #1;
        chk("rst_immediate", outs(), 32'd0);
        tick();
        chk("rst_no_done_a", done, 1'b0);
        tick();
        chk("rst_no_done_b", done, 1'b0);
        reset_n = 1'b1;
        tick();
        chk("rst_release_ready", cmd_ready, 1'b1);
        chk("rst_release_outs", outs(), 32'd0);

        // Right shift with fill 0 and reg_q = 2'b01: rotate feeds reg_q[0]
        reg_q = 2'b01;
        issue(2'b10, 2'b00, 4'd2, 1'b0);
        chk("rot_c1", outs(), pack(2'b01, 2'b00, ROT ? 1'b1 : 1'b0, 0, 0, 4'd2, 0, 0));
        tick();
        chk("rot_c2", rightshift, ROT ? 1'b1 : 1'b0);
        tick();
        chk("rot_done", outs(), pack(2'b00, 2'b00, 0, 0, 0, 4'd0, 1, 0));
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven control stage that sits directly upstream of the universal shift register.
- Accepts one command at a time over a valid/ready handshake: clear, parallel load, shift right by N or shift left by N.
- Generates, cycle by cycle, the register's mode select, parallel data, serial fill bits and synchronous clear.
- Reports completion with a one-cycle done pulse and supports abort.

Parameters:
- WIDTH, 2, width of the driven shift register (parallel data and feedback).
- CNT_W, 4, width of the shift count; maximum shift per command is 2^CNT_W-1.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  00 clear, 01 load, 10 shift right, 11 shift left.
- cmd_data  input  WIDTH  parallel load value (used only by load).
- cmd_count  input  CNT_W  number of shift cycles (used only by shifts).
- cmd_fill  input  1  serial bit shifted in on each shift cycle.
- abort  input  1  terminate the current shift early.
- reg_q  input  WIDTH  current register contents; used only when the optional feature is compiled in.
- sel  output  2  register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- par_out  output  WIDTH  parallel data to the register.
- rightshift  output  1  serial bit entering the MSB on a right shift.
- leftshift  output  1  serial bit entering the LSB on a left shift.
- reg_sync_reset  output  1  synchronous clear to the register.
- busy_cnt  output  CNT_W  shift cycles remaining.
- done  output  1  one-cycle completion pulse.
- aborted  output  1  qualifies done; high when the command ended by abort.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (reset_n).
  - While reset_n is low, state=IDLE.
  - sel, par_out, rightshift, leftshift, reg_sync_reset, busy_cnt, done and aborted are all 0.
- Registers and outputs: all outputs except cmd_ready are registered. cmd_ready is 1 exactly in IDLE.
- States:
  - IDLE: wait for a command.
  - CLR: one cycle, reg_sync_reset=1, sel=00.
  - LOAD: one cycle, sel=11, par_out=cmd_data.
  - SHIFT: sel=01 or 10 for N consecutive cycles.
  - DONE: one cycle, done=1, sel=00, cmd_ready=0; always returns to IDLE.
- Accept: a command is accepted on a rising edge with cmd_valid && cmd_ready. cmd_op, cmd_data, cmd_count and cmd_fill are latched at that edge; later input changes are ignored.
- Latency, with acceptance at edge k:
  - CLR/LOAD active in cycle k+1, done in cycle k+2, cmd_ready back in cycle k+3.
  - Shift N: sel active in cycles k+1..k+N, done in cycle k+N+1.
- Shift cycles:
  - busy_cnt = N in the first shift cycle and decrements each cycle; it is 1 in the last shift cycle and 0 in DONE/IDLE.
  - rightshift/leftshift = latched fill on the active side; the inactive side is 0.
  - par_out holds 0 outside LOAD.
- Count 0: a shift with cmd_count=0 goes directly IDLE→DONE. No active sel cycle occurs and done is in cycle k+1.
- Abort:
  - abort sampled high in a SHIFT cycle forces sel=00 in the next cycle and enters DONE with aborted=1.
  - Abort sampled in the last shift cycle is still reported with aborted=1.
  - abort is ignored in IDLE, CLR, LOAD and DONE.
- Back-to-back: not possible. DONE always inserts one non-ready cycle between commands.
- Reset mid-operation: all outputs clear immediately and no done pulse is issued. After release, state=IDLE with cmd_ready=1.

Optional Feature:
- Macro: SHIFT_SEQ_ROTATE_EN.
- Defined: the fill bit comes from reg_q instead of cmd_fill, turning shifts into rotates.
  - Right shift: rightshift=reg_q[0].
  - Left shift: leftshift=reg_q[WIDTH-1].
  - The fill is registered from reg_q sampled in the same cycle that sel is issued.
- Undefined: reg_q is unused and cmd_fill is used as described above.

Decomposition:
- Package shift_seq_pkg holds:
  - sel encodings SEL_HOLD/SEL_SHR/SEL_SHL/SEL_LOAD;
  - op codes OP_CLR/OP_LOAD/OP_SHR/OP_SHL;
  - the state enum.
- Sub-module shift_seq_downcnt: loadable CNT_W down-counter with a zero flag, driving busy_cnt.

Test Plan:
- Reset held, then released: all outputs 0 during reset; cmd_ready=1 one cycle after release.
- LOAD cmd_data=2'b10: sel=11 and par_out=10 in cycle k+1; done=1 in k+2; ready in k+3.
- SHR count=3, fill=1: sel=01 for 3 cycles with rightshift=1 and busy_cnt 3,2,1; done in k+4 with aborted=0.
- SHL count=5, abort asserted in the 2nd shift cycle: sel=10 for exactly 2 cycles, then done=1 with aborted=1.
- SHR count=0: no active sel cycle; done in k+1. A CLR command then gives reg_sync_reset=1 for exactly 1 cycle.
- reset_n dropped during the 2nd cycle of a count=4 shift: outputs 0 immediately and no done pulse. With SHIFT_SEQ_ROTATE_EN and reg_q=2'b01, a right shift drives rightshift=1.
